// File: rtl/dm_responder.sv
// dm_responder: data memory that is zeroed after reset, with byte-lane CPU writes and an optional store log.
// The write-log FIFO is built only when DM_WRITE_LOG_EN is defined; otherwise the log outputs are tied to 0.
module dm_responder #(
  parameter int DEPTH_LOG2     = 12,
  parameter int LOG_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        mem_ready,
  output logic        oob_seen,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [3:0]  log_byteen,
  output logic [31:0] log_wdata,
  output logic        log_overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_cnt_q, clr_cnt_d;
  logic                  oob_q, oob_d;
  logic [31:0]           mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] word_idx_s, mem_idx_s;
  logic                  in_range_s, run_s, wr_req_s, cpu_wr_s, mem_we_s;
  logic [31:0]           rd_word_s, merged_s, mem_wdata_s;
  logic                  unused_addr_lsb_s;

  assign word_idx_s        = m_data_addr[DEPTH_LOG2+1:2];
  assign in_range_s        = (m_data_addr[31:DEPTH_LOG2+2] == {(30-DEPTH_LOG2){1'b0}});
  assign run_s             = (state_q == ST_RUN);
  assign wr_req_s          = (m_data_byteen != 4'b0000);
  assign cpu_wr_s          = run_s & wr_req_s & in_range_s;
  assign rd_word_s         = mem_q[word_idx_s];
  assign merged_s          = merge_lanes(rd_word_s, m_data_wdata, m_data_byteen);
  assign m_data_rdata      = (run_s && in_range_s) ? rd_word_s : 32'h0000_0000;
  assign mem_ready         = run_s;
  assign oob_seen          = oob_q;
  assign unused_addr_lsb_s = ^m_data_addr[1:0];

  // Clear sequencing, memory write port selection and the sticky out-of-range flag.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    oob_d       = oob_q;
    mem_we_s    = 1'b0;
    mem_idx_s   = word_idx_s;
    mem_wdata_s = merged_s;
    case (state_q)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_idx_s   = clr_cnt_q;
        mem_wdata_s = 32'h0000_0000;
        clr_cnt_d   = clr_cnt_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
        if (clr_cnt_q == {DEPTH_LOG2{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN: begin
        mem_we_s = cpu_wr_s;
        if (wr_req_s && !in_range_s) begin
          oob_d = 1'b1;
        end else begin
          oob_d = oob_q;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= {DEPTH_LOG2{1'b0}};
      oob_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      oob_q     <= oob_d;
    end
  end

  // Memory array: deliberately not reset, the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_idx_s] <= mem_wdata_s;
    end
  end

`ifdef DM_WRITE_LOG_EN
  localparam int LOG_DEPTH = 1 << LOG_DEPTH_LOG2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } log_entry_t;

  log_entry_t                log_mem_q [LOG_DEPTH];
  logic [LOG_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH_LOG2:0]   count_q, count_d;
  logic                      ovf_q, ovf_d;
  logic                      pop_s, full_s, do_push_s;
  log_entry_t                push_entry_s, head_s;

  assign push_entry_s = '{pc: m_inst_addr, addr: {m_data_addr[31:2], 2'b00},
                          be: m_data_byteen, data: merged_s};
  assign pop_s        = (count_q != {(LOG_DEPTH_LOG2+1){1'b0}}) & log_ready;
  assign full_s       = (count_q == {1'b1, {LOG_DEPTH_LOG2{1'b0}}});
  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign do_push_s    = cpu_wr_s & (~full_s | pop_s);

  // FIFO pointer, occupancy and overflow next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + {{(LOG_DEPTH_LOG2-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(LOG_DEPTH_LOG2-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, pop_s})
      2'b10:   count_d = count_q + {{LOG_DEPTH_LOG2{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{LOG_DEPTH_LOG2{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    if (cpu_wr_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {LOG_DEPTH_LOG2{1'b0}};
      rd_ptr_q <= {LOG_DEPTH_LOG2{1'b0}};
      count_q  <= {(LOG_DEPTH_LOG2+1){1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      log_mem_q[wr_ptr_q] <= push_entry_s;
    end
  end

  assign head_s       = log_mem_q[rd_ptr_q];
  assign log_valid    = (count_q != {(LOG_DEPTH_LOG2+1){1'b0}});
  assign log_pc       = head_s.pc;
  assign log_addr     = head_s.addr;
  assign log_byteen   = head_s.be;
  assign log_wdata    = head_s.data;
  assign log_overflow = ovf_q;
`else
  logic unused_log_s;

  assign unused_log_s = ^{log_ready, m_inst_addr};
  assign log_valid    = 1'b0;
  assign log_pc       = 32'h0000_0000;
  assign log_addr     = 32'h0000_0000;
  assign log_byteen   = 4'b0000;
  assign log_wdata    = 32'h0000_0000;
  assign log_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder (DEPTH_LOG2=4, LOG_DEPTH_LOG2=3): vector table plus log scoreboard.
module tb_dm_responder;
`ifdef DM_WRITE_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } log_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic [31:0] exp_merged;
    logic        exp_oob;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr, m_data_wdata, m_inst_addr, m_data_rdata;
  logic [3:0]  m_data_byteen;
  logic        mem_ready, oob_seen, log_valid, log_ready, log_overflow;
  logic [31:0] log_pc, log_addr, log_wdata;
  logic [3:0]  log_byteen;

  log_t        sb_q[$];
  vec_t        vecs [14];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] pc_v, addr_v, data_v;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_LOG2(4), .LOG_DEPTH_LOG2(3)) dut (
    .clk(clk), .reset(reset),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_inst_addr(m_inst_addr), .m_data_rdata(m_data_rdata),
    .mem_ready(mem_ready), .oob_seen(oob_seen),
    .log_valid(log_valid), .log_ready(log_ready),
    .log_pc(log_pc), .log_addr(log_addr), .log_byteen(log_byteen),
    .log_wdata(log_wdata), .log_overflow(log_overflow)
  );

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  // Drive one access, check the combinational read mid-cycle, then the sticky flag after the edge.
  task automatic drive(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rd, input logic [31:0] exp_merged,
                       input logic exp_oob, input bit lg);
    log_t e;
    m_inst_addr   = pc;
    m_data_addr   = addr;
    m_data_wdata  = wdata;
    m_data_byteen = be;
    if (LOG_EN && lg) begin
      e.pc   = pc;
      e.addr = {addr[31:2], 2'b00};
      e.be   = be;
      e.data = exp_merged;
      sb_q.push_back(e);
    end
    @(negedge clk);
    check32("rdata", m_data_rdata, exp_rd);
    @(posedge clk);
    #1;
    check1("oob_seen", oob_seen, exp_oob);
    m_data_byteen = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count edges after reset release: mem_ready must rise on exactly the 16th.
  task automatic check_clear(input string tag);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      check1({tag, "_mem_ready"}, mem_ready, (k == 16));
      check32({tag, "_rdata_zero"}, m_data_rdata, 32'h0);
    end
  endtask

  // Log monitor: every entry the consumer accepts must match the scoreboard head.
  always @(negedge clk) begin
    log_t e;
`ifdef DM_WRITE_LOG_EN
    if (reset && log_valid && log_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL log_extra: got pc 0x%08h, want no entry", log_pc);
      end else begin
        e = sb_q.pop_front();
        check32("log_pc", log_pc, e.pc);
        check32("log_addr", log_addr, e.addr);
        check32("log_byteen", {28'h0, log_byteen}, {28'h0, e.be});
        check32("log_wdata", log_wdata, e.data);
      end
    end
`else
    e = '0;
    check32("log_tieoff", log_pc | log_addr | log_wdata |
            {26'h0, log_byteen, log_valid, log_overflow}, {e.pc});
`endif
  end

  initial begin
    vecs[0]  = '{32'h1000, 32'h0000_0008, 32'h1122_3344, 4'hF, 32'h0,         32'h1122_3344, 1'b0};
    vecs[1]  = '{32'h1004, 32'h0000_0008, 32'h00AA_0000, 4'h4, 32'h1122_3344, 32'h11AA_3344, 1'b0};
    vecs[2]  = '{32'h1008, 32'h0000_0008, 32'h0,         4'h0, 32'h11AA_3344, 32'h0,         1'b0};
    vecs[3]  = '{32'h100C, 32'h0000_000A, 32'h0000_00FF, 4'h1, 32'h11AA_3344, 32'h11AA_33FF, 1'b0};
    vecs[4]  = '{32'h1010, 32'h0000_003C, 32'hCAFE_F00D, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[5]  = '{32'h1014, 32'h0000_003C, 32'h0,         4'h0, 32'hCAFE_F00D, 32'h0,         1'b0};
    vecs[6]  = '{32'h1018, 32'h0000_0040, 32'h0,         4'h0, 32'h0,         32'h0,         1'b0};
    vecs[7]  = '{32'h101C, 32'h0001_0000, 32'h0,         4'h0, 32'h0,         32'h0,         1'b0};
    vecs[8]  = '{32'h1020, 32'h0000_0008, 32'h0,         4'h0, 32'h11AA_33FF, 32'h0,         1'b0};
    vecs[9]  = '{32'h1024, 32'h0001_0008, 32'hFFFF_FFFF, 4'hF, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{32'h1028, 32'h0000_0008, 32'h0,         4'h0, 32'h11AA_33FF, 32'h0,         1'b1};
    vecs[11] = '{32'h102C, 32'h0000_000C, 32'h5566_7788, 4'hA, 32'h0,         32'h5500_7700, 1'b1};
    vecs[12] = '{32'h1030, 32'h0000_000C, 32'h0,         4'h0, 32'h5500_7700, 32'h0,         1'b1};
    vecs[13] = '{32'h1034, 32'h0000_0000, 32'h0,         4'h0, 32'h0,         32'h0,         1'b1};

    reset         = 1'b0;
    log_ready     = 1'b0;
    m_data_addr   = 32'h8;
    m_data_wdata  = 32'h0;
    m_data_byteen = 4'h0;
    m_inst_addr   = 32'h0;
    #1;
    check1("rst_mem_ready", mem_ready, 1'b0);
    check1("rst_oob", oob_seen, 1'b0);
    check1("rst_log_valid", log_valid, 1'b0);
    check1("rst_overflow", log_overflow, 1'b0);
    check32("rst_rdata", m_data_rdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_clear("boot");

    log_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].pc, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_rd,
            vecs[i].exp_merged, vecs[i].exp_oob,
            (vecs[i].be != 4'h0) && (vecs[i].addr[31:6] == 26'h0));
    end
    idle(3);
    check1("table_drained", log_valid, 1'b0);
    check32("table_sb_empty", 32'(sb_q.size()), 32'h0);

    // Nine writes with the consumer stalled: the ninth is dropped.
    log_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pc_v   = 32'h3000 + 32'(4 * i);
      addr_v = (i == 0) ? 32'h6 : 32'h10 + 32'(4 * (i - 1));
      data_v = (i == 0) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(i);
      drive(pc_v, addr_v, data_v, 4'hF, 32'h0, data_v, 1'b1, i < 8);
      if (i == 0) begin
        check1("first_log_valid", log_valid, LOG_EN);
        check32("first_log_pc", log_pc, LOG_EN ? 32'h3000 : 32'h0);
        check32("first_log_addr", log_addr, LOG_EN ? 32'h4 : 32'h0);
        check32("first_log_wdata", log_wdata, LOG_EN ? 32'hDEAD_BEEF : 32'h0);
        check32("first_log_byteen", {28'h0, log_byteen}, LOG_EN ? 32'hF : 32'h0);
      end
    end
    check1("full_overflow", log_overflow, LOG_EN);
    check1("full_valid", log_valid, LOG_EN);
    check32("full_head_pc", log_pc, LOG_EN ? 32'h3000 : 32'h0);

    // Reset in RUN with entries pending, then again mid-clear.
    reset = 1'b0;
    #1;
    check1("midrun_log_valid", log_valid, 1'b0);
    check1("midrun_mem_ready", mem_ready, 1'b0);
    check1("midrun_overflow", log_overflow, 1'b0);
    check1("midrun_oob", oob_seen, 1'b0);
    check32("midrun_rdata", m_data_rdata, 32'h0);
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(5);
    reset = 1'b0;
    #1;
    check1("midclear_mem_ready", mem_ready, 1'b0);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    m_data_addr = 32'h3C;
    check_clear("restart");
    drive(32'h0, 32'h8, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Fill the FIFO, then push and pop together while full.
    log_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pc_v   = 32'h4000 + 32'(4 * i);
      addr_v = 32'h10 + 32'(4 * i);
      data_v = 32'hB000_0000 + 32'(i);
      if (i == 8) log_ready = 1'b1;
      drive(pc_v, addr_v, data_v, 4'hF, 32'h0, data_v, 1'b0, 1'b1);
    end
    check1("fullpop_no_overflow", log_overflow, 1'b0);
    idle(10);
    check1("fullpop_drained", log_valid, 1'b0);
    check32("fullpop_sb_empty", 32'(sb_q.size()), 32'h0);

    // Back-to-back push and pop at occupancy one.
    for (int i = 0; i < 3; i++) begin
      pc_v   = 32'h5000 + 32'(4 * i);
      addr_v = 32'h34 + 32'(4 * i);
      data_v = 32'hC000_0000 + 32'(i);
      drive(pc_v, addr_v, data_v, 4'hF, 32'h0, data_v, 1'b0, 1'b1);
      check1("occ1_valid", log_valid, LOG_EN);
    end
    idle(1);
    check1("occ1_empty", log_valid, 1'b0);
    idle(2);
    check32("final_sb_empty", 32'(sb_q.size()), 32'h0);
    check1("final_overflow", log_overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
